// File: rtl/pattern_scan_ctrl.sv
// Sequencer for an external serial "1101" Moore detector: clears it, shifts a word in MSB first, counts matches.
// Latency: done pulses WORD_W+2 cycles after the accepting edge; one word per WORD_W+4 cycles at best.
// Backpressure: word_ready is high only in IDLE; optional abort port under PATTERN_SCAN_ABORT_EN.
module pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PATTERN_SCAN_ABORT_EN
    input  logic              abort,
`endif
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              det_clear,
    output logic              det_bit,
    input  logic              det_o,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              found
);

    localparam int                IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] sreg_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  run_cnt_nxt;
    logic              sample;
    logic              abort_req;
    logic              abort_take;
    logic              det_bit_nxt;
    logic              det_clear_nxt;
    logic              word_ready_nxt;
    logic              busy_nxt;
    logic              done_nxt;

`ifdef PATTERN_SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        idx_nxt     = idx;
        run_cnt_nxt = run_cnt;
        sample      = 1'b0;
        abort_take  = 1'b0;

        case (state)
            S_IDLE: begin
                if (word_valid && word_ready) begin
                    sreg_nxt    = word_data;
                    run_cnt_nxt = '0;
                    state_nxt   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_nxt   = '0;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // det_o lags det_bit by one cycle, so the first SHIFT cycle has nothing to sample yet
                sample   = (idx != '0);
                sreg_nxt = {sreg[WORD_W-2:0], 1'b0};
                idx_nxt  = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sample    = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (sample && det_o && (run_cnt != CNT_MAX)) begin
            run_cnt_nxt = run_cnt + 1'b1;
        end

        if (abort_req && (state == S_CLEAR || state == S_SHIFT || state == S_DRAIN)) begin
            abort_take  = 1'b1;
            state_nxt   = S_IDLE;
            run_cnt_nxt = '0;
        end

        // Outputs are registered, so they are derived from the state being entered
        det_bit_nxt    = (state_nxt == S_SHIFT) ? sreg_nxt[WORD_W-1] : 1'b0;
        det_clear_nxt  = (state_nxt == S_CLEAR) || abort_take;
        word_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt       = (state_nxt == S_CLEAR) || (state_nxt == S_SHIFT) || (state_nxt == S_DRAIN);
        done_nxt       = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sreg       <= '0;
            idx        <= '0;
            run_cnt    <= '0;
            match_cnt  <= '0;
            found      <= 1'b0;
            done       <= 1'b0;
            det_bit    <= 1'b0;
            det_clear  <= 1'b1;
            word_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            idx        <= idx_nxt;
            run_cnt    <= run_cnt_nxt;
            done       <= done_nxt;
            det_bit    <= det_bit_nxt;
            det_clear  <= det_clear_nxt;
            word_ready <= word_ready_nxt;
            busy       <= busy_nxt;
            // Result becomes visible together with the done pulse
            if (state_nxt == S_DONE) begin
                match_cnt <= run_cnt_nxt;
                found     <= (run_cnt_nxt != '0);
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: two instances (CNT_W=4 and CNT_W=1) each driving a behavioural "1101" detector.
module tb_pattern_scan_ctrl;
    localparam int W = 8;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic         rst = 1'b1;
    logic         word_valid = 1'b0;
    logic [W-1:0] word_data = '0;
`ifdef PATTERN_SCAN_ABORT_EN
    logic         abort = 1'b0;
`endif

    logic       word_ready0, det_clear0, det_bit0, det_o0, busy0, done0, found0;
    logic [3:0] match_cnt0;
    logic       word_ready1, det_clear1, det_bit1, det_o1, busy1, done1, found1;
    logic [0:0] match_cnt1;

    int errors = 0;
    int checks = 0;

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(4)) u_dut0 (
        .clk(tb_clk), .rst(rst),
`ifdef PATTERN_SCAN_ABORT_EN
        .abort(abort),
`endif
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready0),
        .det_clear(det_clear0), .det_bit(det_bit0), .det_o(det_o0), .busy(busy0),
        .done(done0), .match_cnt(match_cnt0), .found(found0)
    );

    pattern_scan_ctrl #(.WORD_W(W), .CNT_W(1)) u_dut1 (
        .clk(tb_clk), .rst(rst),
`ifdef PATTERN_SCAN_ABORT_EN
        .abort(abort),
`endif
        .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready1),
        .det_clear(det_clear1), .det_bit(det_bit1), .det_o(det_o1), .busy(busy1),
        .done(done1), .match_cnt(match_cnt1), .found(found1)
    );

    // Detector: Moore output is high when the last four bits since clear were 1,1,0,1
    logic [3:0] hist0 = '0;
    logic [3:0] hist1 = '0;
    always @(posedge tb_clk) begin
        hist0 <= det_clear0 ? 4'b0000 : {hist0[2:0], det_bit0};
        hist1 <= det_clear1 ? 4'b0000 : {hist1[2:0], det_bit1};
    end
    assign det_o0 = (hist0 == 4'b1101);
    assign det_o1 = (hist1 == 4'b1101);

    logic bits_seen [0:15];
    logic clr_seen  [0:15];

    function automatic int ref_count(input logic [W-1:0] w, input int maxv);
        int c = 0;
        for (int i = 0; i <= W - 4; i++) begin
            if (w[W-1-i -: 4] == 4'b1101) c++;
        end
        return (c > maxv) ? maxv : c;
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (word_ready0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Presents one word, then watches 30 cycles for done; lat=-1 if done never rose
    task automatic run_word(input logic [W-1:0] w, output int lat, output int done_cnt);
        lat = -1;
        done_cnt = 0;
        wait_ready();
        word_valid = 1'b1;
        word_data  = w;
        tick();
        word_valid = 1'b0;
        word_data  = W'($urandom);
        clr_seen[0]  = det_clear0;
        bits_seen[0] = det_bit0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c < 16) begin
                bits_seen[c] = det_bit0;
                clr_seen[c]  = det_clear0;
            end
            if (done0 === 1'b1) begin
                if (lat < 0) lat = c;
                done_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (word_ready0 !== 1'b0) begin errors++; $display("FAIL reset_word_ready got=%b exp=0", word_ready0); end
        checks++; if (det_clear0 !== 1'b1) begin errors++; $display("FAIL reset_det_clear got=%b exp=1", det_clear0); end
        checks++; if ({busy0, done0, det_bit0, found0} !== 4'b0000) begin errors++; $display("FAIL reset_busy_done_bit_found got=%b exp=0000", {busy0, done0, det_bit0, found0}); end
        checks++; if (match_cnt0 !== 4'd0) begin errors++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt0); end
        rst = 1'b0;
        tick();
        checks++; if ({word_ready0, det_clear0} !== 2'b10) begin errors++; $display("FAIL reset_release ready_clear got=%b exp=10", {word_ready0, det_clear0}); end
    endtask

    task automatic test_basic();
        logic [W-1:0] w = 8'b1101_0000;
        logic [W-1:0] seq;
        logic [11:0]  clr;
        int lat, dn;
        run_word(w, lat, dn);
        for (int i = 0; i < W; i++) seq[W-1-i] = bits_seen[1+i];
        for (int i = 0; i < 12; i++) clr[i] = clr_seen[i];
        checks++; if (seq !== w) begin errors++; $display("FAIL basic_det_bit_seq got=%b exp=%b", seq, w); end
        checks++; if (bits_seen[W+1] !== 1'b0) begin errors++; $display("FAIL basic_drain_bit got=%b exp=0", bits_seen[W+1]); end
        checks++; if (clr !== 12'h001) begin errors++; $display("FAIL basic_det_clear_pulse got=%b exp=%b", clr, 12'h001); end
        checks++; if (lat !== W + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 2); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dn); end
        checks++; if ({match_cnt0, found0} !== {4'd1, 1'b1}) begin errors++; $display("FAIL basic_result got=%0d/%b exp=1/1", match_cnt0, found0); end
    endtask

    task automatic test_patterns();
        logic [W-1:0] fixed [3] = '{8'b1101_1010, 8'b1011_0110, 8'hFF};
        logic [W-1:0] w;
        logic [3:0]   e0;
        logic [0:0]   e1;
        int lat, dn, pos;
        for (int t = 0; t < 27; t++) begin
            if (t < 3) w = fixed[t];
            else begin
                w = W'($urandom);
                if ($urandom_range(1, 0) == 1) begin
                    pos = $urandom_range(W - 4, 0);
                    w[pos +: 4] = 4'b1101;
                end
            end
            e0 = 4'(ref_count(w, 15));
            e1 = 1'(ref_count(w, 1));
            run_word(w, lat, dn);
            checks++; if (lat !== W + 2 || dn !== 1) begin errors++; $display("FAIL pattern_timing w=%b lat=%0d pulses=%0d exp lat=%0d pulses=1", w, lat, dn, W + 2); end
            checks++; if (match_cnt0 !== e0 || found0 !== (e0 != 0)) begin errors++; $display("FAIL pattern_count w=%b got=%0d/%b exp=%0d/%b", w, match_cnt0, found0, e0, e0 != 0); end
            checks++; if (match_cnt1 !== e1 || found1 !== e1[0]) begin errors++; $display("FAIL pattern_sat_count w=%b got=%0d/%b exp=%0d", w, match_cnt1, found1, e1); end
        end
    endtask

    task automatic test_back_to_back();
        int lat, dn, n_acc, n_done, clr_after;
        int t_done [2];
        logic [3:0] c_done [2];
        logic rdy_b;
        run_word(8'b1101_1010, lat, dn);
        checks++; if (match_cnt0 !== 4'd2) begin errors++; $display("FAIL b2b_prior got=%0d exp=2", match_cnt0); end
        n_acc = 0; n_done = 0; clr_after = -1;
        wait_ready();
        word_valid = 1'b1;
        word_data  = 8'b0000_0110;
        for (int c = 0; c < 60; c++) begin
            rdy_b = word_ready0;
            tick();
            if (rdy_b && word_valid) begin
                n_acc++;
                if (n_acc == 1) word_data = 8'b1000_0000;
                else begin
                    word_valid = 1'b0;
                    clr_after  = int'(det_clear0);
                end
            end
            if (done0 === 1'b1 && n_done < 2) begin
                t_done[n_done] = c;
                c_done[n_done] = match_cnt0;
                n_done++;
            end
        end
        word_valid = 1'b0;
        checks++; if (n_done !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        else begin
            checks++; if (t_done[1] - t_done[0] !== W + 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", t_done[1] - t_done[0], W + 4); end
            checks++; if (c_done[0] !== 4'd0 || c_done[1] !== 4'd0) begin errors++; $display("FAIL b2b_counts got=%0d,%0d exp=0,0", c_done[0], c_done[1]); end
        end
        checks++; if (clr_after !== 1) begin errors++; $display("FAIL b2b_second_clear got=%0d exp=1", clr_after); end
        checks++; if (found0 !== 1'b0) begin errors++; $display("FAIL b2b_found got=%b exp=0", found0); end
    endtask

    task automatic test_reset_mid();
        int lat, dn, n_done;
        run_word(8'b1101_0000, lat, dn);
        wait_ready();
        word_valid = 1'b1;
        word_data  = 8'b1101_1101;
        tick();
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", busy0); end
        rst = 1'b1;
        tick();
        checks++; if ({det_clear0, word_ready0, busy0, done0} !== 4'b1000) begin errors++; $display("FAIL rstmid_outputs clr_rdy_busy_done got=%b exp=1000", {det_clear0, word_ready0, busy0, done0}); end
        checks++; if (match_cnt0 !== 4'd0 || found0 !== 1'b0) begin errors++; $display("FAIL rstmid_cleared got=%0d/%b exp=0/0", match_cnt0, found0); end
        rst = 1'b0;
        tick();
        checks++; if (word_ready0 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", word_ready0); end
        checks++; if (hist0 !== 4'b0000) begin errors++; $display("FAIL rstmid_detector_cleared got=%b exp=0000", hist0); end
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 === 1'b1) n_done++;
        end
        checks++; if (n_done !== 0 || match_cnt0 !== 4'd0) begin errors++; $display("FAIL rstmid_no_done pulses=%0d cnt=%0d exp 0/0", n_done, match_cnt0); end
    endtask

    task automatic test_busy_ignore();
        int acc_c, n_done;
        logic [3:0] c0 [2];
        logic [0:0] c1;
        logic rdy_b;
        acc_c = -1; n_done = 0; c1 = '0;
        wait_ready();
        word_valid = 1'b1;
        word_data  = 8'b1101_1010;
        tick();
        word_data  = 8'b1011_0110;
        for (int c = 1; c <= 40; c++) begin
            rdy_b = word_ready0;
            tick();
            if (rdy_b && word_valid) begin
                word_valid = 1'b0;
                acc_c = c;
            end
            if (done0 === 1'b1 && n_done < 2) begin
                c0[n_done] = match_cnt0;
                if (n_done == 0) c1 = match_cnt1;
                n_done++;
            end
        end
        word_valid = 1'b0;
        checks++; if (acc_c !== W + 4) begin errors++; $display("FAIL busy_second_accept got=%0d exp=%0d", acc_c, W + 4); end
        checks++; if (n_done !== 2) begin errors++; $display("FAIL busy_done_count got=%0d exp=2", n_done); end
        else begin
            checks++; if (c0[0] !== 4'd2) begin errors++; $display("FAIL busy_first_result got=%0d exp=2", c0[0]); end
            checks++; if (c1 !== 1'b1) begin errors++; $display("FAIL busy_saturated got=%0d exp=1", c1); end
            checks++; if (c0[1] !== 4'd1) begin errors++; $display("FAIL busy_second_result got=%0d exp=1", c0[1]); end
        end
    endtask

`ifdef PATTERN_SCAN_ABORT_EN
    task automatic test_abort();
        int lat, dn, n_done;
        run_word(8'b1101_1010, lat, dn);
        wait_ready();
        word_valid = 1'b1;
        word_data  = 8'b1101_1101;
        tick();
        word_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({det_clear0, busy0, done0, word_ready0} !== 4'b1001) begin errors++; $display("FAIL abort_outputs clr_busy_done_rdy got=%b exp=1001", {det_clear0, busy0, done0, word_ready0}); end
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 === 1'b1) n_done++;
        end
        checks++; if (n_done !== 0 || match_cnt0 !== 4'd2 || found0 !== 1'b1) begin errors++; $display("FAIL abort_hold pulses=%0d cnt=%0d exp 0/2", n_done, match_cnt0); end
        run_word(8'b1011_0110, lat, dn);
        checks++; if (lat !== W + 2 || match_cnt0 !== 4'd1) begin errors++; $display("FAIL abort_next_scan lat=%0d cnt=%0d exp %0d/1", lat, match_cnt0, W + 2); end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_busy_ignore();
`ifdef PATTERN_SCAN_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Sequencer for the external serial "1101" Moore sequence detector.
- Accepts a parallel word over a valid/ready handshake and clears the detector before the word.
- Feeds the word to the detector one bit per clock, MSB first.
- Samples the detector output after each bit, counts matches, and reports the count with a one-cycle done pulse.
- Sits between a word producer and the detector; the detector instance lives outside this block.

Parameters:
WORD_W, 8, width of the scanned word (legal range 4..32).
CNT_W, 4, width of the match counter; saturates at 2^CNT_W-1.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  reset; one clock; reset is synchronous and active-high.
word_valid  input  1  producer presents word_data.
word_data  input  WORD_W  word to scan; bit WORD_W-1 is sent first.
word_ready  output  1  block can accept a word (IDLE only).
det_clear  output  1  drives the detector reset; returns the detector to its start state.
det_bit  output  1  serial bit to the detector input i.
det_o  input  1  detector Moore output o.
busy  output  1  high in CLEAR, SHIFT and DRAIN.
done  output  1  one-cycle pulse when a scan completes.
match_cnt  output  CNT_W  number of matches in the last scan; held until the next done.
found  output  1  match_cnt != 0; held with match_cnt.

Behaviour:
- Reset: while rst=1 at a clock edge, the block enters IDLE and sets match_cnt=0, found=0, done=0 and det_bit=0. In that same reset cycle det_clear=1, word_ready=0 and busy=0. The word register and bit index are cleared. All outputs are registered.
- Reset mid-operation: aborts at once. The word is discarded, done does not pulse and match_cnt is cleared.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - word_ready=1, det_clear=0, det_bit=0.
  - On word_valid&&word_ready at an edge: capture word_data, zero the running count, go to CLEAR.
- CLEAR (1 cycle):
  - det_clear=1, det_bit=0.
  - Go to SHIFT with idx=0.
- SHIFT (WORD_W cycles):
  - det_bit=sreg[WORD_W-1]; sreg shifts left by one each cycle; idx increments.
  - det_o is sampled only when idx>=1; it reflects the bit driven in the previous cycle.
  - When idx=WORD_W-1 the next state is DRAIN.
- DRAIN (1 cycle):
  - det_bit=0; sample det_o for the last bit.
  - Go to DONE.
- DONE (1 cycle):
  - done=1; match_cnt and found are loaded from the running count.
  - Return to IDLE; word_ready=1 again in the next cycle.
- Match counting:
  - WORD_W samples in total: SHIFT idx 1..WORD_W-1 plus DRAIN.
  - The count increments by one for each sample with det_o=1 and saturates at 2^CNT_W-1 with no wrap.
- Latency and throughput:
  - done is high exactly WORD_W+2 cycles after the accepting edge.
  - Maximum throughput is one word per WORD_W+4 cycles.
- Detector clearing: the detector is cleared before every word, so a pattern that spans a word boundary is never counted.
- Handshake:
  - word_data is ignored when word_ready=0.
  - The producer holds word_valid/word_data until the handshake completes.
  - word_valid held high in DONE is accepted on the first IDLE cycle.
- busy equals the state being in {CLEAR, SHIFT, DRAIN}.

Optional Feature:
- Macro: PATTERN_SCAN_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in CLEAR, SHIFT or DRAIN: next state is IDLE, det_clear=1 for that next cycle, the running count is discarded, done does not pulse, and match_cnt/found keep their previous values.
  - abort in IDLE or DONE is ignored, so DONE still pulses.
  - rst has priority over abort.
- Undefined: no abort port; scans always run to completion.

Test Plan:
- Reset, then word 8'b1101_0000 -> det_clear pulses 1 cycle, det_bit sequence 1,1,0,1,0,0,0,0; done 10 cycles after accept; match_cnt=1, found=1.
- Word 8'b1101_1010 (overlapping) -> match_cnt=2; word 8'b1011_0110 -> match_cnt=1; word 8'hFF -> match_cnt=0, found=0.
- Back-to-back words 8'b0000_0110 then 8'b1000_0000 with word_valid held high -> two done pulses 12 cycles apart, each match_cnt=0; det_clear high before the second word.
- Assert rst during SHIFT at idx=3 of word 8'b1101_1101 -> no done, match_cnt=0, word_ready=1 the cycle after rst drops, detector cleared.
- word_valid asserted while busy with a new word_data value -> ignored until IDLE; the original scan's result is unchanged; with CNT_W=1, word 8'b1101_1010 -> match_cnt saturates at 1.
- (PATTERN_SCAN_ABORT_EN) abort at SHIFT idx=5 -> IDLE next cycle, det_clear=1, no done, match_cnt keeps its prior value; the next word scans normally.
